// File: rtl/flp_pkg.sv
// -----------------------------------------------------------------------------
// flp_pkg
// Shared types and helpers for the FLP/NLP link-pulse transmitter.
//   flp_state_e  : transmitter FSM states
//   FLP_MODE / NLP_MODE : values of the mode input
//   slot_count() : number of slots in one burst for a given mode
// -----------------------------------------------------------------------------
package flp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        WAIT  = 2'd2
    } flp_state_e;

    localparam logic FLP_MODE = 1'b0;
    localparam logic NLP_MODE = 1'b1;

    // FLP: clock slot + data slot per bit, plus a trailing clock slot.
    // NLP: a lone clock slot.
    function automatic int slot_count(input int word_w, input logic mode);
        return (mode == NLP_MODE) ? 1 : 2 * word_w + 1;
    endfunction

endpackage

// File: rtl/flp_lcw_if.sv
// -----------------------------------------------------------------------------
// flp_lcw_if
// Valid/ready link-code-word handshake between the auto-negotiation arbiter
// (master) and the burst transmitter (slave).
//   lcw_data  : next link code word
//   lcw_valid : lcw_data valid
//   lcw_ready : transmitter holding register empty
// -----------------------------------------------------------------------------
interface flp_lcw_if #(
    parameter int WORD_W = 16
);
    logic [WORD_W-1:0] lcw_data;
    logic              lcw_valid;
    logic              lcw_ready;

    modport master (output lcw_data, output lcw_valid, input  lcw_ready);
    modport slave  (input  lcw_data, input  lcw_valid, output lcw_ready);
endinterface

// File: rtl/flp_slot_timer.sv
// -----------------------------------------------------------------------------
// flp_slot_timer
// Slot cycle counter and slot index for one link-pulse burst.
//   clk, rst_n    : clock, async active-low reset
//   start         : next cycle is burst cycle 0 (counters load 0)
//   run           : advance the counters (burst in progress)
//   nlp           : burst length selector (mode of the burst)
//   slot_first    : position is cycle 0 of a slot
//   pulse_window  : position is within the pulse width of a slot
//   last_slot_end : position is the final cycle of the burst
//   slot_idx      : slot index of the position
// All decodes describe the position the counters take on the NEXT cycle, so
// the parent can register its outputs and still have them line up with the
// burst cycle they describe.
// -----------------------------------------------------------------------------
module flp_slot_timer
    import flp_pkg::*;
#(
    parameter int WORD_W    = 16,
    parameter int PULSE_CYC = 2,
    parameter int SLOT_CYC  = 1250
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 start,
    input  logic                                 run,
    input  logic                                 nlp,
    output logic                                 slot_first,
    output logic                                 pulse_window,
    output logic                                 last_slot_end,
    output logic [$clog2(2*WORD_W+1)-1:0]        slot_idx
);

    localparam int CW = $clog2(SLOT_CYC);
    localparam int IW = $clog2(2 * WORD_W + 1);

    localparam logic [CW-1:0] CYC_LAST  = CW'(SLOT_CYC - 1);
    localparam logic [CW-1:0] PULSE_END = CW'(PULSE_CYC);

    logic [CW-1:0] cyc_q, cyc_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [IW-1:0] last_idx;

    // Outside a burst the counters sit at zero; start wins over run so a
    // back-to-back burst restarts cleanly from the last cycle of the previous.
    always_comb begin
        cyc_d = '0;
        idx_d = '0;
        if (!start && run) begin
            if (cyc_q == CYC_LAST) begin
                cyc_d = '0;
                idx_d = idx_q + 1'b1;
            end else begin
                cyc_d = cyc_q + 1'b1;
                idx_d = idx_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_q <= '0;
            idx_q <= '0;
        end else begin
            cyc_q <= cyc_d;
            idx_q <= idx_d;
        end
    end

    assign last_idx      = IW'(slot_count(WORD_W, nlp) - 1);
    assign slot_first    = (cyc_d == '0);
    assign pulse_window  = (cyc_d < PULSE_END);
    assign last_slot_end = (cyc_d == CYC_LAST) && (idx_d == last_idx);
    assign slot_idx      = idx_d;

endmodule

// File: rtl/flp_burst_tx.sv
// -----------------------------------------------------------------------------
// flp_burst_tx
// Fast Link Pulse / Normal Link Pulse burst transmitter for 10BASE-T
// auto-negotiation. All timing in clock cycles.
//   clk, resetn  : clock, async active-low reset
//   enable       : transmitter enable (a started burst always completes)
//   mode         : 0 = FLP, 1 = NLP, sampled at burst start
//   lcw          : valid/ready link code word input (holding register)
//   tx_pulse     : link pulse to the shaper
//   burst_start  : strobe in the first cycle of each burst
//   burst_done   : strobe in the last cycle of each burst
//   active_word  : word currently being sent
// Every output is a flop; the *_d terms are built from next-cycle state so
// each output is valid in the burst cycle it refers to.
// -----------------------------------------------------------------------------
module flp_burst_tx
    import flp_pkg::*;
#(
    parameter int WORD_W     = 16,
    parameter int PULSE_CYC  = 2,
    parameter int SLOT_CYC   = 1250,
    parameter int PERIOD_CYC = 320000
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              enable,
    input  logic              mode,
    flp_lcw_if.slave          lcw,
    output logic              tx_pulse,
    output logic              burst_start,
    output logic              burst_done,
    output logic [WORD_W-1:0] active_word
);

    localparam int PW = $clog2(PERIOD_CYC);
    localparam int IW = $clog2(2 * WORD_W + 1);

    localparam logic [PW-1:0] PER_LAST = PW'(PERIOD_CYC - 1);

    flp_state_e        state_q, state_d;
    logic [PW-1:0]     period_q, period_d;
    logic              mode_q, mode_d;
    logic              hold_full_q, hold_full_d;
    logic [WORD_W-1:0] hold_data_q, hold_data_d;
    logic [WORD_W-1:0] active_q, active_d;
    logic              slot_on_q, slot_on_d;
    logic              tx_pulse_q, tx_pulse_d;
    logic              burst_start_q, burst_start_d;
    logic              burst_done_q, burst_done_d;

    logic              go;          // next cycle is burst cycle 0
    logic              timer_run;
    logic              load, xfer;
    logic              in_burst_n;
    logic              slot_first, pulse_window, last_slot_end;
    logic [IW-1:0]     slot_idx;
    logic [WORD_W-1:0] bit_sh;

    // ---------------------------------------------------------------- FSM --
    // burst_done_q marks the current cycle as the last of the burst, so the
    // FSM never needs to look at the timer decodes directly.
    always_comb begin
        state_d  = state_q;
        period_d = period_q;
        go       = 1'b0;
        case (state_q)
            IDLE: begin
                period_d = '0;
                if (enable) go = 1'b1;
            end
            BURST: begin
                if (period_q != PER_LAST) period_d = period_q + 1'b1;
                if (burst_done_q) begin
                    // Burst may fill the whole period: decide the restart here.
                    if (period_q == PER_LAST) begin
                        if (enable) begin
                            go = 1'b1;
                        end else begin
                            state_d  = IDLE;
                            period_d = '0;
                        end
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (!enable) begin
                    state_d  = IDLE;
                    period_d = '0;
                end else if (period_q == PER_LAST) begin
                    go = 1'b1;
                end else begin
                    period_d = period_q + 1'b1;
                end
            end
            default: begin
                state_d  = IDLE;
                period_d = '0;
            end
        endcase
        if (go) begin
            state_d  = BURST;
            period_d = '0;
        end
    end

    assign timer_run = (state_q == BURST) && !burst_done_q;

    flp_slot_timer #(
        .WORD_W    (WORD_W),
        .PULSE_CYC (PULSE_CYC),
        .SLOT_CYC  (SLOT_CYC)
    ) u_slot_timer (
        .clk           (clk),
        .rst_n         (resetn),
        .start         (go),
        .run           (timer_run),
        .nlp           (mode_d),
        .slot_first    (slot_first),
        .pulse_window  (pulse_window),
        .last_slot_end (last_slot_end),
        .slot_idx      (slot_idx)
    );

    // ----------------------------------------------------------- datapath --
    // load and xfer are mutually exclusive (xfer needs an empty register, load
    // a full one), so a word arriving at a burst start stays held for the
    // following burst while this one repeats the previous word.
    always_comb begin
        load        = go && hold_full_q;
        xfer        = lcw.lcw_valid && !hold_full_q;
        hold_full_d = hold_full_q;
        hold_data_d = hold_data_q;
        active_d    = active_q;
        mode_d      = mode_q;
        if (load) begin
            active_d    = hold_data_q;
            hold_full_d = 1'b0;
        end
        if (xfer) begin
            hold_full_d = 1'b1;
            hold_data_d = lcw.lcw_data;
        end
        if (go) mode_d = mode;

        in_burst_n = (state_d == BURST);

        // Even slots are clock pulses; odd slot k carries bit (k-1)/2, which
        // is slot_idx >> 1 for odd indices. The decision is taken once at the
        // first cycle of each slot and held for the rest of it.
        bit_sh    = active_d >> slot_idx[IW-1:1];
        slot_on_d = slot_first ? (!slot_idx[0] || bit_sh[0]) : slot_on_q;

        tx_pulse_d    = in_burst_n && pulse_window && slot_on_d;
        burst_start_d = go;
        burst_done_d  = in_burst_n && last_slot_end;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= IDLE;
            period_q      <= '0;
            mode_q        <= FLP_MODE;
            hold_full_q   <= 1'b0;
            hold_data_q   <= '0;
            active_q      <= '0;
            slot_on_q     <= 1'b0;
            tx_pulse_q    <= 1'b0;
            burst_start_q <= 1'b0;
            burst_done_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            period_q      <= period_d;
            mode_q        <= mode_d;
            hold_full_q   <= hold_full_d;
            hold_data_q   <= hold_data_d;
            active_q      <= active_d;
            slot_on_q     <= slot_on_d;
            tx_pulse_q    <= tx_pulse_d;
            burst_start_q <= burst_start_d;
            burst_done_q  <= burst_done_d;
        end
    end

    assign lcw.lcw_ready = !hold_full_q;
    assign tx_pulse      = tx_pulse_q;
    assign burst_start   = burst_start_q;
    assign burst_done    = burst_done_q;
    assign active_word   = active_q;

endmodule

// File: tb/tb_flp_burst_tx.sv
// -----------------------------------------------------------------------------
// tb_flp_burst_tx
// Scoreboard bench for flp_burst_tx (WORD_W=16, PULSE_CYC=2, SLOT_CYC=10,
// PERIOD_CYC=400). Stimulus pushes the expected burst records; a negedge
// monitor reconstructs each burst (word, pulsed-slot mask, pulse count and
// width, done offset, start-to-start gap) and compares on burst_done.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_flp_burst_tx;

    typedef struct {
        logic [15:0] word;
        logic [32:0] mask;
        int          npulse;
        int          done_off;
        int          gap;      // 0: first burst after idle, gap not checked
    } exp_t;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic enable = 1'b0;
    logic mode = 1'b0;
    logic tx_pulse, burst_start, burst_done;
    logic [15:0] active_word;

    flp_lcw_if #(.WORD_W(16)) lcw_bus ();

    flp_burst_tx #(
        .WORD_W(16), .PULSE_CYC(2), .SLOT_CYC(10), .PERIOD_CYC(400)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .enable      (enable),
        .mode        (mode),
        .lcw         (lcw_bus),
        .tx_pulse    (tx_pulse),
        .burst_start (burst_start),
        .burst_done  (burst_done),
        .active_word (active_word)
    );

    always #5 clk = ~clk;

    int   n_vec  = 0;
    int   n_miss = 0;
    exp_t exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_miss++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    function automatic exp_t mk(input logic [15:0] w, input logic [32:0] m,
                                input int np, input int d, input int g);
        exp_t e;
        e.word = w; e.mask = m; e.npulse = np; e.done_off = d; e.gap = g;
        return e;
    endfunction

    // ------------------------------------------------------------ monitor --
    int          n_start = 0, n_done = 0, stray_idle = 0;
    int          abs_cyc = 0, last_start = 0, cur_gap = 0;
    int          off = 0, npulse = 0, hi = 0, stray_b = 0;
    logic        in_b = 1'b0, prev_tx = 1'b0;
    logic [32:0] mask = '0;
    logic [15:0] mword = '0;
    exp_t        me;

    always @(negedge clk) begin
        if (!resetn) begin
            in_b    = 1'b0;
            prev_tx = 1'b0;
        end else begin
            abs_cyc++;
            if (burst_start) begin
                in_b = 1'b1; off = 0; mask = '0; npulse = 0; hi = 0; stray_b = 0;
                mword = active_word;
                cur_gap = abs_cyc - last_start;
                last_start = abs_cyc;
                n_start++;
            end
            if (in_b) begin
                if (tx_pulse) begin
                    hi++;
                    if (!prev_tx) begin
                        npulse++;
                        if ((off % 10) == 0 && (off / 10) <= 32) mask[off / 10] = 1'b1;
                        else stray_b++;
                    end
                end
                if (burst_done) begin
                    n_done++;
                    in_b = 1'b0;
                    if (exp_q.size() == 0) begin
                        n_vec++; n_miss++;
                        $display("FAIL unexpected_burst: got burst word %0h, none required", mword);
                    end else begin
                        me = exp_q.pop_front();
                        chk("burst_word",   mword,  me.word);
                        chk("slot_mask",    mask,   me.mask);
                        chk("pulse_count",  npulse, me.npulse);
                        chk("pulse_cycles", hi,     2 * me.npulse);
                        chk("done_offset",  off,    me.done_off);
                        chk("offgrid_pulse", stray_b, 0);
                        if (me.gap != 0) chk("start_gap", cur_gap, me.gap);
                    end
                end
                off++;
            end else if (tx_pulse || burst_done) begin
                stray_idle++;
            end
            prev_tx = tx_pulse;
        end
    end

    // ---------------------------------------------------------- stimulus --
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int target, input int budget);
        int k = 0;
        while (n_done < target && k < budget) begin tick(1); k++; end
        if (n_done < target) begin
            n_vec++; n_miss++;
            $display("FAIL wait_done: got %0d bursts done, required %0d", n_done, target);
        end
    endtask

    task automatic wait_start(input int budget);
        int k = 0;
        do begin tick(1); k++; end while (!burst_start && k < budget);
        if (!burst_start) begin
            n_vec++; n_miss++;
            $display("FAIL wait_start: got no burst_start within %0d cycles, required one", budget);
        end
    endtask

    localparam logic [32:0] M_05E1 = 33'h1_5577_FD57;
    localparam logic [32:0] M_AAAA = 33'h1_DDDD_DDDD;
    localparam logic [32:0] M_5555 = 33'h1_7777_7777;
    localparam logic [32:0] M_NLP  = 33'h0_0000_0001;

    initial begin
        logic bad;
        int   d0, s0;
        lcw_bus.lcw_data  = '0;
        lcw_bus.lcw_valid = 1'b0;

        // Reset state
        tick(3);
        chk("rst_tx_pulse", tx_pulse, 0);
        chk("rst_ready", lcw_bus.lcw_ready, 1);
        chk("rst_active", active_word, 0);
        chk("rst_strobes", {burst_start, burst_done}, 0);
        resetn = 1'b1;

        // Idle with enable low for 50 cycles
        bad = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick(1);
            if (tx_pulse || !lcw_bus.lcw_ready || active_word != 0 || burst_start || burst_done)
                bad = 1'b1;
        end
        chk("idle_quiet", bad, 0);

        // FLP with 16'h05E1, two bursts, then drop enable in WAIT (cycle 350)
        lcw_bus.lcw_data = 16'h05E1; lcw_bus.lcw_valid = 1'b1;
        tick(1);
        lcw_bus.lcw_valid = 1'b0;
        chk("ready_after_write", lcw_bus.lcw_ready, 0);
        exp_q.push_back(mk(16'h05E1, M_05E1, 23, 329, 0));
        exp_q.push_back(mk(16'h05E1, M_05E1, 23, 329, 400));
        enable = 1'b1;
        wait_done(2, 1200);
        tick(20);
        enable = 1'b0;
        tick(500);
        chk("wait_drop_idle", n_start, 2);
        chk("idle_stray_a", stray_idle, 0);

        // Handshake: AAAA held, 5555 presented immediately behind it
        d0 = n_done; s0 = n_start;
        lcw_bus.lcw_data = 16'hAAAA; lcw_bus.lcw_valid = 1'b1;
        tick(1);
        lcw_bus.lcw_data = 16'h5555;
        chk("ready_full", lcw_bus.lcw_ready, 0);
        tick(5);
        chk("ready_still_full", lcw_bus.lcw_ready, 0);
        exp_q.push_back(mk(16'hAAAA, M_AAAA, 25, 329, 0));
        exp_q.push_back(mk(16'h5555, M_5555, 25, 329, 400));
        exp_q.push_back(mk(16'h5555, M_5555, 25, 329, 400));
        exp_q.push_back(mk(16'h5555, M_5555, 25, 329, 400));
        enable = 1'b1;
        wait_start(50);
        chk("ready_at_start", lcw_bus.lcw_ready, 1);
        chk("active_aaaa", active_word, 16'hAAAA);
        tick(1);
        lcw_bus.lcw_valid = 1'b0;
        chk("ready_took_5555", lcw_bus.lcw_ready, 0);
        wait_done(d0 + 3, 1300);
        // Burst 4: drop enable at burst cycle 100, burst must still complete
        wait_start(200);
        tick(100);
        enable = 1'b0;
        wait_done(d0 + 4, 400);
        tick(500);
        chk("burst_drop_idle", n_start, s0 + 4);
        chk("idle_stray_b", stray_idle, 0);

        // NLP: one pulse per period, done at cycle 9
        d0 = n_done;
        exp_q.push_back(mk(16'h5555, M_NLP, 1, 9, 0));
        exp_q.push_back(mk(16'h5555, M_NLP, 1, 9, 400));
        mode = 1'b1; enable = 1'b1;
        wait_done(d0 + 2, 900);
        tick(5);
        enable = 1'b0;
        mode = 1'b0;
        tick(450);
        chk("nlp_stops", n_done, d0 + 2);
        chk("idle_stray_c", stray_idle, 0);

        // Reset in the middle of the slot-4 clock pulse
        enable = 1'b1;
        wait_start(50);
        tick(41);
        chk("pulse_at_41", tx_pulse, 1);
        resetn = 1'b0;
        enable = 1'b0;
        #1;
        chk("mid_rst_tx_pulse", tx_pulse, 0);
        chk("mid_rst_ready", lcw_bus.lcw_ready, 1);
        chk("mid_rst_active", active_word, 0);
        chk("mid_rst_strobes", {burst_start, burst_done}, 0);
        tick(2);
        resetn = 1'b1;
        tick(20);
        chk("post_rst_quiet", tx_pulse, 0);
        chk("scoreboard_empty", exp_q.size(), 0);
        chk("idle_stray_d", stray_idle, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/flp_burst_tx.md
Name: flp_burst_tx

Overview:
Parametrised link-pulse transmitter for the 10BASE-T auto-negotiation path. It generates Fast Link Pulse bursts that carry a WORD_W-bit link code word, or Normal Link Pulses in NLP mode, with all timings set in clock cycles. A valid/ready holding register lets the arbitration logic queue the next page while the current one is being sent. It sits between the auto-negotiation arbiter and the TX pulse shaper.

Parameters:
WORD_W, 16, link code word width; a burst has 2*WORD_W+1 slots
PULSE_CYC, 2, pulse width in cycles (100 ns at 20 MHz)
SLOT_CYC, 1250, slot length in cycles (62.5 us); must be > PULSE_CYC
PERIOD_CYC, 320000, burst start-to-start period (16 ms); must be >= (2*WORD_W+1)*SLOT_CYC

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous reset, active low
enable  in  1  transmitter enable
mode  in  1  0 = FLP, 1 = NLP; sampled at burst start
lcw_data  in  WORD_W  next link code word
lcw_valid  in  1  lcw_data valid
lcw_ready  out  1  holding register empty
tx_pulse  out  1  link pulse to shaper
burst_start  out  1  1-cycle strobe in the first cycle of each burst
burst_done  out  1  1-cycle strobe in the last cycle of each burst
active_word  out  WORD_W  word currently being sent

Behaviour:
- Reset (async, resetn=0): state IDLE, all counters 0, tx_pulse=0, burst_start=0, burst_done=0, lcw_ready=1, holding register empty, active_word=0.
- States: IDLE, BURST, WAIT.
- IDLE: tx_pulse=0. When enable=1, the next cycle is burst cycle 0 (state BURST).
- Burst cycle 0:
  - burst_start=1.
  - mode is latched.
  - If the holding register is full, it is transferred to active_word and the holding register empties. Otherwise the previous active_word repeats.
- Handshake: a transfer occurs when lcw_valid && lcw_ready; the holding register then becomes full and lcw_ready goes 0 the following cycle. If a transfer and a burst-0 load happen in the same cycle, the burst uses the old holding contents. The new word stays held, so lcw_ready remains 0.
- FLP slots, k = 0 .. 2*WORD_W:
  - Even k is a clock slot and always pulses.
  - Odd k carries bit (k-1)/2 of active_word, LSB first. It pulses only if that bit is 1.
  - A pulsing slot drives tx_pulse=1 for burst cycles k*SLOT_CYC .. k*SLOT_CYC+PULSE_CYC-1; tx_pulse is 0 otherwise.
- NLP: a single clock slot (k=0) only.
- burst_done=1 in cycle S*SLOT_CYC-1, where S = 2*WORD_W+1 (FLP) or 1 (NLP). The block then enters WAIT.
- WAIT: the period counter, which runs from burst cycle 0, reaches PERIOD_CYC-1. If enable=1, the next cycle is the next burst's cycle 0; otherwise the block goes to IDLE.
- enable=0 during BURST: the burst completes in full; there is no truncation.
- enable=0 during WAIT: the block goes to IDLE next cycle.
- Counters:
  - Slot cycle counter: $clog2(SLOT_CYC) bits, wraps at SLOT_CYC-1.
  - Slot index: $clog2(2*WORD_W+1) bits.
  - Period counter: $clog2(PERIOD_CYC) bits; it never wraps past PERIOD_CYC-1.
- Reset mid-burst: immediate return to reset values; no partial pulse continues.
- All outputs are registered.

Decomposition:
- Package flp_pkg:
  - state enum (IDLE, BURST, WAIT)
  - mode constants (FLP_MODE=0, NLP_MODE=1)
  - function slot_count(word_w, mode)
- Sub-module flp_slot_timer: slot cycle counter plus slot index. Outputs slot_first (cycle 0 of a slot), pulse_window (cycle < PULSE_CYC), last_slot_end, and slot_idx. Top level holds FSM, period counter, holding/active registers, pulse select.

Test Plan:
- Bench parameters for all scenarios: WORD_W=16, PULSE_CYC=2, SLOT_CYC=10, PERIOD_CYC=400.
- Reset, then hold enable=0 for 50 cycles -> tx_pulse=0, lcw_ready=1, active_word=0, no strobes.
- Write lcw_data=16'h05E1, then enable=1, mode=0:
  - active_word=16'h05E1 and burst_start at cycle 0.
  - Exactly 17+6=23 pulses, each 2 cycles wide, at multiples of 10.
  - Bit 0 pulse at cycle 10; bit 1 slot at cycle 30 empty.
  - burst_done at cycle 329; next burst_start at cycle 400.
- Handshake:
  - Load 16'hAAAA, then present 16'h5555 immediately -> lcw_ready=0 until the next burst_start.
  - 16'h5555 is accepted only after that burst_start; burst 2 sends 16'h5555.
  - With no new word, burst 3 repeats 16'h5555.
- mode=1 -> one 2-cycle pulse per 400 cycles; burst_done at cycle 9.
- Drop enable at burst cycle 100 -> the burst completes (burst_done at 329), then IDLE and no further pulses.
- Drop enable during WAIT at cycle 350 -> IDLE.
- Assert resetn=0 at burst cycle 41, while tx_pulse=1 -> tx_pulse=0 immediately, lcw_ready=1, active_word=0.
